// File: rtl/opt_cipher_pkg.sv
// Shared cipher definitions for the opt byte-stream encryptor/decryptor pair and their benches.
// Holds default widths, the sequencer state encoding and the reference rotate/cipher functions.
package opt_cipher_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_KEY_WORDS = 8;
  localparam int DEF_ROT_W     = $clog2(DEF_DATA_W);

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ROT_W-1:0]  rot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CALC  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Rotations go through a doubled copy so a zero shift needs no special case.
  function automatic data_t rol_byte(input data_t v, input rot_t sh);
    return data_t'(({v, v} << sh) >> DEF_DATA_W);
  endfunction

  function automatic data_t ror_byte(input data_t v, input rot_t sh);
    return data_t'({v, v} >> sh);
  endfunction

  function automatic data_t enc_byte(input data_t pt, input data_t k);
    return rol_byte(pt ^ k, k[DEF_ROT_W-1:0]);
  endfunction

  function automatic data_t dec_byte(input data_t ct, input data_t k);
    return ror_byte(ct, k[DEF_ROT_W-1:0]) ^ k;
  endfunction

endpackage

// File: rtl/opt_stream_decryptor_if.sv
// Stream, key-fetch and status signals of the opt stream decryptor.
// The slave view belongs to the decryptor, the master view to whatever drives it.
interface opt_stream_decryptor_if
  import opt_cipher_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic [7:0]        byte_count;

  modport slave (
    input  start, in_valid, in_data, rf_data, out_ready,
    output in_ready, rf_addr, out_valid, out_data, busy, byte_count
  );

  modport master (
    output start, in_valid, in_data, rf_data, out_ready,
    input  in_ready, rf_addr, out_valid, out_data, busy, byte_count
  );
endinterface

// File: rtl/opt_dec_core.sv
// Combinational inverse cipher: plaintext = rotate-right(ct, key low bits) xor key.
// Rotation is circular on DATA_W bits.
module opt_dec_core
  import opt_cipher_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] ct,
  input  logic [DATA_W-1:0] key,
  output logic [DATA_W-1:0] pt
);
  localparam int ROT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] rotated;

  assign rotated = DATA_W'({ct, ct} >> key[ROT_W-1:0]);
  assign pt      = rotated ^ key;
endmodule

// File: rtl/opt_stream_decryptor.sv
// Byte-stream decryptor: accepts one ciphertext byte, fetches its key from the register file,
// decrypts and holds the plaintext until downstream takes it. One byte in flight at a time.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a ciphertext byte
//   FETCH | rf_addr = key index, key sampled at the closing edge
//   CALC  | plaintext registered, out_valid raised at the closing edge
//   HOLD  | plaintext offered until out_ready, then count/index advance
module opt_stream_decryptor
  import opt_cipher_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int KEY_WORDS = DEF_KEY_WORDS
) (
  input  logic                   clock,
  input  logic                   reset,
  opt_stream_decryptor_if.slave  bus
);
  state_t            state_q, state_d;
  logic              accept, deliver;
  logic [DATA_W-1:0] ct_q, key_q, pt;
  logic [ADDR_W-1:0] idx_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [7:0]        count_q;

  opt_dec_core #(.DATA_W(DATA_W)) u_core (
    .ct  (ct_q),
    .key (key_q),
    .pt  (pt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // start overrides every handshake, so it is resolved before the state decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    deliver = 1'b0;
    if (bus.start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_d = FETCH;
          end
        end
        FETCH: state_d = CALC;
        CALC:  state_d = HOLD;
        HOLD: begin
          if (bus.out_ready) begin
            deliver = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ct_q        <= '0;
      key_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      if (accept) ct_q <= bus.in_data;
      if (state_q == FETCH && !bus.start) key_q <= bus.rf_data;
      if (bus.start) begin
        out_valid_q <= 1'b0;
        idx_q       <= '0;
        count_q     <= '0;
      end else begin
        if (state_q == CALC) begin
          out_data_q  <= pt;
          out_valid_q <= 1'b1;
        end
        if (deliver) begin
          out_valid_q <= 1'b0;
          count_q     <= count_q + 8'd1;
          idx_q       <= (idx_q == ADDR_W'(KEY_WORDS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.rf_addr    = idx_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.byte_count = count_q;
endmodule

// File: tb/tb_opt_stream_decryptor.sv
// Scoreboard bench for opt_stream_decryptor: expected plaintext is queued as ciphertext is
// generated with enc_byte and compared when the decryptor hands a byte downstream.
module tb_opt_stream_decryptor;
  import opt_cipher_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  opt_stream_decryptor_if bus ();
  data_t keys [DEF_KEY_WORDS];

  assign bus.rf_data = keys[bus.rf_addr];

  opt_stream_decryptor dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  data_t sb_q[$];
  int    idx_m = 0;
  int    cnt_m = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench one step after the accepting edge, i.e. with the DUT in FETCH.
  task automatic send(input data_t ct, input data_t pt_exp);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    tick();
    bus.in_valid = 1'b0;
    sb_q.push_back(pt_exp);
    chk("rf_addr_fetch", bus.rf_addr, idx_m);
    chk("busy_fetch", bus.busy, 1);
  endtask

  // Latency counts rising edges, the accepting edge being the first.
  task automatic wait_out();
    int lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("out_valid_wait", bus.out_valid, 1);
    chk("latency", lat, 3);
  endtask

  task automatic finish_out(input int hold, input bit poke);
    data_t e = '0;
    chk("sb_nonempty", sb_q.size() != 0, 1);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    chk("out_data", bus.out_data, e);
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = poke;
      bus.in_data  = 8'hE7;
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, e);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_rf_addr", bus.rf_addr, idx_m);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    idx_m = (idx_m + 1) % DEF_KEY_WORDS;
    cnt_m = (cnt_m + 1) % 256;
    chk("byte_count", bus.byte_count, cnt_m);
    chk("out_valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    idx_m = 0;
    cnt_m = 0;
    chk("start_count", bus.byte_count, 0);
    chk("start_idle", bus.in_ready, 1);
  endtask

  task automatic run_byte(input data_t pt);
    data_t ct = enc_byte(pt, keys[idx_m]);
    send(ct, pt);
    wait_out();
    finish_out(0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    data_t pt;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    keys = '{8'h3B, 8'hA4, 8'h07, 8'hF2, 8'h5D, 8'h96, 8'hC1, 8'h68};
    keys[0] = 8'hAA;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_rf_addr", bus.rf_addr, 0);
    chk("rst_count", bus.byte_count, 0);
    chk("rst_busy", bus.busy, 0);

    // Known-answer vector: key AA rotates by 2.
    send(8'h5A, 8'h3C);
    wait_out();
    finish_out(0, 1'b0);

    // Zero key: identity.
    pulse_start();
    keys[0] = 8'h00;
    send(8'hFF, 8'hFF);
    wait_out();
    finish_out(0, 1'b0);

    // Nine bytes across all keys, index wraps back to 0.
    pulse_start();
    keys = '{8'h3B, 8'hA4, 8'h07, 8'hF2, 8'h5D, 8'h96, 8'hC1, 8'h68};
    for (int i = 0; i < 9; i++) begin
      pt = data_t'($urandom_range(0, 255));
      run_byte(pt);
    end
    chk("count_nine", bus.byte_count, 9);

    // Downstream stall with a stray in_valid that must be ignored.
    pt = 8'h81;
    send(enc_byte(pt, keys[idx_m]), pt);
    wait_out();
    finish_out(5, 1'b1);
    chk("no_stray_accept", bus.busy, 0);

    // start while holding a byte at index 3.
    pulse_start();
    for (int i = 0; i < 3; i++) run_byte(data_t'(8'h10 + i));
    pt = 8'h4C;
    send(enc_byte(pt, keys[idx_m]), pt);
    wait_out();
    chk("hold_idx3", bus.rf_addr, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_count", bus.byte_count, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rf_addr", bus.rf_addr, 0);
    void'(sb_q.pop_back());
    idx_m = 0;
    cnt_m = 0;
    run_byte(8'hC3);

    // Asynchronous reset between edges while in FETCH.
    pt = 8'h2E;
    send(enc_byte(pt, keys[idx_m]), pt);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_rf_addr", bus.rf_addr, 0);
    chk("arst_count", bus.byte_count, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    #2;
    reset = 1'b0;
    void'(sb_q.pop_back());
    idx_m = 0;
    cnt_m = 0;
    tick();
    run_byte(8'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
